// File: rtl/branch_target_predictor_pkg.sv
// Shared constants for the IF-stage branch target predictor: geometry,
// branch type codes and 2-bit saturating counter codes.
package branch_target_predictor_pkg;

    localparam int BP_INDEX_BITS = 6;

    // Branch type codes as carried down the pipe from decode
    localparam logic [2:0] BR_NOBRANCH = 3'd0;
    localparam logic [2:0] BR_BEQ      = 3'd1;
    localparam logic [2:0] BR_BNE      = 3'd2;
    localparam logic [2:0] BR_BLT      = 3'd3;
    localparam logic [2:0] BR_BLTU     = 3'd4;
    localparam logic [2:0] BR_BGE      = 3'd5;
    localparam logic [2:0] BR_BGEU     = 3'd6;

    // Saturating counter codes; bit 1 is the taken prediction
    typedef enum logic [1:0] {
        BP_SNT = 2'b00,
        BP_WNT = 2'b01,
        BP_WT  = 2'b10,
        BP_ST  = 2'b11
    } bp_ctr_t;

    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/branch_target_predictor_counter.sv
// Next-state function of a 2-bit saturating branch counter.
module bp_counter_next
    import branch_target_predictor_pkg::*;
(
    input  logic [1:0] ctr,
    input  logic       taken,
    output logic [1:0] ctr_next
);

    // Step towards the resolved direction, holding at either end
    always_comb begin
        ctr_next = ctr;
        if (taken) begin
            if (ctr != BP_ST)
                ctr_next = ctr + 2'd1;
        end else begin
            if (ctr != BP_SNT)
                ctr_next = ctr - 2'd1;
        end
    end

endmodule

// File: rtl/branch_target_predictor.sv
// Direct-mapped BTB with 2-bit saturating counters. Zero-latency lookup of
// PCF, EX-stage mispredict detection and one training write per cycle.
// Optional feature macro: BRANCH_STATS_EN adds BranchCntE / MissCntE.
module branch_target_predictor
    import branch_target_predictor_pkg::*;
#(
    parameter int INDEX_BITS = BP_INDEX_BITS
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] PCF,
    output logic        PredTakenF,
    output logic [31:0] PredTargetF,
    input  logic        EnE,
    input  logic [31:0] PCE,
    input  logic [2:0]  BranchTypeE,
    input  logic        BranchE,
    input  logic [31:0] BrTargetE,
    input  logic        PredTakenE,
    input  logic [31:0] PredTargetE,
    output logic        MispredictE,
    output logic [31:0] CorrectPCE
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0] BranchCntE,
    output logic [31:0] MissCntE
`endif
);

    localparam int ENTRIES  = 1 << INDEX_BITS;
    localparam int TAG_BITS = 30 - INDEX_BITS;

    logic                valid_q  [ENTRIES];
    logic [TAG_BITS-1:0] tag_q    [ENTRIES];
    logic [31:0]         target_q [ENTRIES];
    logic [1:0]          ctr_q    [ENTRIES];

    logic [INDEX_BITS-1:0] idx_f, idx_e;
    logic [TAG_BITS-1:0]   tag_f, tag_e;
    logic                  hit_f, hit_e;
    logic                  is_branch_e;
    logic [1:0]            ctr_next_e;
    logic                  unused_pc_lsbs;

    assign idx_f = PCF[INDEX_BITS+1:2];
    assign tag_f = PCF[31:INDEX_BITS+2];
    assign idx_e = PCE[INDEX_BITS+1:2];
    assign tag_e = PCE[31:INDEX_BITS+2];

    // Instruction-aligned PCs: the low two bits never select anything
    assign unused_pc_lsbs = ^{PCF[1:0], PCE[1:0]};

    assign is_branch_e = (BranchTypeE != BR_NOBRANCH);

    // Fetch-side lookup from the registered array; reads see pre-update contents
    always_comb begin
        hit_f       = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
        PredTakenF  = !rst && hit_f && ctr_q[idx_f][1];
        PredTargetF = (!rst && hit_f) ? target_q[idx_f] : pc_plus4(PCF);
    end

    // EX-side hit check used to decide between update, allocate and purge
    always_comb begin
        hit_e = valid_q[idx_e] && (tag_q[idx_e] == tag_e);
    end

    bp_counter_next u_ctr_next (
        .ctr      (ctr_q[idx_e]),
        .taken    (BranchE),
        .ctr_next (ctr_next_e)
    );

    // Compare the prediction carried to EX against the resolved outcome
    always_comb begin
        MispredictE = 1'b0;
        if (EnE && !rst) begin
            if (is_branch_e)
                MispredictE = (PredTakenE != BranchE) ||
                              (PredTakenE && BranchE && (PredTargetE != BrTargetE));
            else
                MispredictE = PredTakenE;
        end
        CorrectPCE = (!rst && is_branch_e && BranchE) ? BrTargetE : pc_plus4(PCE);
    end

    // Training: counter/target update on hit, allocate on taken miss, purge non-branch hits
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= BP_WNT;
            end
        end else if (EnE) begin
            if (is_branch_e) begin
                if (hit_e) begin
                    ctr_q[idx_e] <= ctr_next_e;
                    if (BranchE)
                        target_q[idx_e] <= BrTargetE;
                end else if (BranchE) begin
                    valid_q[idx_e]  <= 1'b1;
                    tag_q[idx_e]    <= tag_e;
                    target_q[idx_e] <= BrTargetE;
                    ctr_q[idx_e]    <= BP_WT;
                end
            end else if (hit_e) begin
                valid_q[idx_e] <= 1'b0;
            end
        end
    end

`ifdef BRANCH_STATS_EN
    // Free-running resolved-branch and mispredict counters, wrapping at 2^32
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            BranchCntE <= '0;
            MissCntE   <= '0;
        end else begin
            if (EnE && is_branch_e)
                BranchCntE <= BranchCntE + 32'd1;
            if (MispredictE)
                MissCntE <= MissCntE + 32'd1;
        end
    end
`endif

endmodule
